// File: rtl/spi_byte_master_pkg.sv
// Shared types and constants for the single-byte SPI mode-0 master.
package spi_byte_master_pkg;

    localparam int unsigned WORD_W = 8;
    localparam int unsigned CDIV_W = 2;
    localparam int unsigned HCNT_W = 5;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        HIGH,
        LOW,
        FIN
    } state_t;

    // Half-period of sck in clk cycles: 2, 4, 8 or 16.
    function automatic logic [HCNT_W-1:0] half_period(input logic [CDIV_W-1:0] cdiv);
        return HCNT_W'(2) << cdiv;
    endfunction

endpackage

// File: rtl/spi_byte_master_if.sv
// Host-side request/response and SPI pin bundle for spi_byte_master.
interface spi_byte_master_if;
    import spi_byte_master_pkg::*;

    logic              mlb;
    logic              start;
    logic [WORD_W-1:0] tdat;
    logic [CDIV_W-1:0] cdiv;
    logic              din;
    logic              ss;
    logic              sck;
    logic              dout;
    logic              done;
    logic [WORD_W-1:0] rdata;

    modport master (
        input  mlb,
        input  start,
        input  tdat,
        input  cdiv,
        input  din,
        output ss,
        output sck,
        output dout,
        output done,
        output rdata
    );

    modport slave (
        output mlb,
        output start,
        output tdat,
        output cdiv,
        output din,
        input  ss,
        input  sck,
        input  dout,
        input  done,
        input  rdata
    );

endinterface

// File: rtl/spi_half_period_timer.sv
// Down-counter for one sck phase: load H, tick while the count sits at zero.
module spi_half_period_timer
    import spi_byte_master_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [HCNT_W-1:0] period,
    output logic              tick
);

    logic [HCNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= period - 1'b1;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/spi_byte_master.sv
// Single-byte SPI mode-0 master: shifts tdat out on dout while capturing din into rdata.
module spi_byte_master
    import spi_byte_master_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    spi_byte_master_if.master bus
);

    state_t            state;
    logic              start_q;
    logic              start_edge;
    logic              mlb_q;
    logic [CDIV_W-1:0] cdiv_q;
    logic [WORD_W-1:0] tx_sr;
    logic [WORD_W-1:0] tx_shift;
    logic              tx_bit;
    logic [WORD_W-1:0] rx_sr;
    logic [WORD_W-1:0] rx_next;
    logic [3:0]        bcnt;
    logic              ss_q;
    logic              sck_q;
    logic              dout_q;
    logic              done_q;
    logic [WORD_W-1:0] rdata_q;
    logic              load;
    logic              tick;
    logic [HCNT_W-1:0] period;

    always_comb begin
        start_edge = bus.start & ~start_q;

        // Each phase reloads the timer on its last cycle; the IDLE reload uses the live cdiv
        // because the latched copy only becomes valid at that same edge.
        load = 1'b0;
        if (state == IDLE) begin
            load = start_edge;
        end else if (state inside {LEAD, HIGH, LOW}) begin
            load = tick;
        end
        period = (state == IDLE) ? half_period(bus.cdiv) : half_period(cdiv_q);

        tx_bit   = mlb_q ? tx_sr[WORD_W-1] : tx_sr[0];
        tx_shift = mlb_q ? {tx_sr[WORD_W-2:0], 1'b0} : {1'b0, tx_sr[WORD_W-1:1]};
        rx_next  = mlb_q ? {rx_sr[WORD_W-2:0], bus.din} : {bus.din, rx_sr[WORD_W-1:1]};
    end

    spi_half_period_timer u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .period (period),
        .tick   (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            start_q <= 1'b0;
            mlb_q   <= 1'b0;
            cdiv_q  <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            bcnt    <= '0;
            ss_q    <= 1'b1;
            sck_q   <= 1'b0;
            dout_q  <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            start_q <= bus.start;
            case (state)
                IDLE: begin
                    if (start_edge) begin
                        state  <= LEAD;
                        mlb_q  <= bus.mlb;
                        cdiv_q <= bus.cdiv;
                        bcnt   <= '0;
                        ss_q   <= 1'b0;
                        done_q <= 1'b0;
                        dout_q <= bus.mlb ? bus.tdat[WORD_W-1] : bus.tdat[0];
                        tx_sr  <= bus.mlb ? {bus.tdat[WORD_W-2:0], 1'b0}
                                          : {1'b0, bus.tdat[WORD_W-1:1]};
                    end
                end
                LEAD: begin
                    if (tick) begin
                        state <= HIGH;
                        sck_q <= 1'b1;
                        rx_sr <= rx_next;
                    end
                end
                HIGH: begin
                    if (tick) begin
                        state <= LOW;
                        sck_q <= 1'b0;
                        bcnt  <= bcnt + 1'b1;
                        // The last falling edge leaves dout on bit 7.
                        if (bcnt != 4'(WORD_W - 1)) begin
                            dout_q <= tx_bit;
                            tx_sr  <= tx_shift;
                        end
                    end
                end
                LOW: begin
                    if (tick) begin
                        if (bcnt == 4'(WORD_W)) begin
                            state   <= FIN;
                            ss_q    <= 1'b1;
                            done_q  <= 1'b1;
                            rdata_q <= rx_sr;
                        end else begin
                            state <= HIGH;
                            sck_q <= 1'b1;
                            rx_sr <= rx_next;
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ss    = ss_q;
    assign bus.sck   = sck_q;
    assign bus.dout  = dout_q;
    assign bus.done  = done_q;
    assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_spi_byte_master.sv
// Self-checking bench for spi_byte_master: table vectors, hand-written corner sequences, random transfers.
module tb_spi_byte_master;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    int   din_mode;   // 0: constant din_drv, 1: loopback dout->din, 2: random per cycle
    logic din_drv;
    bit   had_xfer;

    typedef struct {
        logic [7:0] tdat;
        logic       mlb;
        logic [1:0] cdiv;
        int         din_mode;
        logic       din_val;
        int         hold;
        int         repulse;
        int         tail;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t       vecs [6];
    logic [7:0] frame [12];

    spi_byte_master_if bus ();

    spi_byte_master dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.din = (din_mode == 1) ? bus.dout : din_drv;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // One complete transfer, observed on negedges, against timing and data rules.
    task automatic xfer(input vec_t v);
        int         h;
        int         idx;
        int         hs;
        int         rises;
        int         done_bad;
        int         sck_out;
        int         extra;
        int         limit;
        bit         in_xfer;
        bit         finished;
        logic       prev_sck;
        logic [7:0] seq_exp;
        logic [7:0] seq_got;
        logic [7:0] rx_exp;
        logic       cap[$];

        h = 2 << v.cdiv;
        for (int i = 0; i < 8; i++) seq_exp[7-i] = v.mlb ? v.tdat[7-i] : v.tdat[i];
        idx = 0; hs = 0; rises = 0; done_bad = 0; sck_out = 0; extra = 0;
        in_xfer = 0; finished = 0; prev_sck = 1'b0; seq_got = '0;
        limit = 17 * h + 40;

        @(negedge clk);
        if (had_xfer) chk("done_held_idle", 32'(bus.done), 32'd1);
        bus.tdat  = v.tdat;
        bus.mlb   = v.mlb;
        bus.cdiv  = v.cdiv;
        bus.start = 1'b1;
        din_mode  = v.din_mode;
        din_drv   = v.din_val;

        for (int c = 0; c < limit && !finished; c++) begin
            @(negedge clk);
            if (!in_xfer && bus.ss == 1'b0) begin
                in_xfer = 1;
                idx = 0;
            end
            if (in_xfer) begin
                if (bus.ss == 1'b1) begin
                    finished = 1;
                    chk("ss_low_clocks", 32'(idx), 32'(17 * h));
                    chk("sck_pulses", 32'(rises), 32'd8);
                    chk("dout_seq", 32'(seq_got), 32'(seq_exp));
                    chk("done_at_end", 32'(bus.done), 32'd1);
                    if (v.din_mode == 2) begin
                        rx_exp = '0;
                        for (int i = 0; i < cap.size() && i < 8; i++) begin
                            if (v.mlb) rx_exp[7-i] = cap[i];
                            else       rx_exp[i]   = cap[i];
                        end
                    end else begin
                        rx_exp = v.exp_rd;
                    end
                    chk("rdata", 32'(bus.rdata), 32'(rx_exp));
                end else begin
                    if (bus.done) done_bad++;
                    if (bus.sck && !prev_sck) begin
                        if (rises < 8) chk("sck_rise_offset", 32'(idx), 32'(h + 2 * h * rises));
                        seq_got = {seq_got[6:0], bus.dout};
                        cap.push_back(bus.din);
                        rises++;
                        hs = idx;
                    end
                    if (!bus.sck && prev_sck) chk("sck_high_clocks", 32'(idx - hs), 32'(h));
                    idx++;
                end
            end else if (bus.sck) begin
                sck_out++;
            end
            prev_sck = bus.sck;

            if (c + 1 == v.hold) bus.start = 1'b0;
            if (v.repulse > 0 && c == v.repulse)     bus.start = 1'b1;
            if (v.repulse > 0 && c == v.repulse + 1) bus.start = 1'b0;
            if (c == 3) begin
                bus.tdat = ~v.tdat;
                bus.mlb  = ~v.mlb;
                bus.cdiv = v.cdiv + 2'd1;
            end
            if (din_mode == 2) din_drv = 1'($urandom);
        end

        if (!finished) chk("xfer_timeout", 32'd0, 32'd1);
        chk("done_low_while_busy", 32'(done_bad), 32'd0);
        chk("sck_idle_low", 32'(sck_out), 32'd0);
        had_xfer = finished;

        if (v.tail > 0) begin
            for (int c = 0; c < v.tail; c++) begin
                @(negedge clk);
                if (bus.ss == 1'b0) extra++;
            end
            chk("single_transfer", 32'(extra), 32'd0);
        end
        bus.start = 1'b0;
    endtask

    initial begin
        int   rises;
        logic ps;
        vec_t rv;

        tests = 0; fails = 0; had_xfer = 0;
        din_mode = 0; din_drv = 1'b0;
        rst = 1'b1;
        bus.start = 1'b0; bus.mlb = 1'b1; bus.tdat = '0; bus.cdiv = '0;

        //              tdat   mlb   cdiv  din  dval  hold rep tail exp
        vecs[0] = '{8'h5A, 1'b1, 2'd0, 1, 1'b0, 2,  -1, 4,  8'h5A};
        vecs[1] = '{8'h01, 1'b0, 2'd1, 0, 1'b1, 2,  -1, 4,  8'hFF};
        vecs[2] = '{8'hA5, 1'b1, 2'd3, 1, 1'b0, 2,  -1, 4,  8'hA5};
        vecs[3] = '{8'h3C, 1'b0, 2'd0, 1, 1'b0, 2,  12, 6,  8'h3C};
        vecs[4] = '{8'h96, 1'b1, 2'd0, 1, 1'b0, 10, -1, 6,  8'h96};
        vecs[5] = '{8'hE1, 1'b0, 2'd2, 0, 1'b0, 1,  -1, 2,  8'h00};

        frame = '{8'h5A, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00,
                  8'h03, 8'h09, 8'h00, 8'h00, 8'h00, 8'h00};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_ss", 32'(bus.ss), 32'd1);
        chk("reset_sck", 32'(bus.sck), 32'd0);
        chk("reset_dout", 32'(bus.dout), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_rdata", 32'(bus.rdata), 32'd0);

        // Abort at the 4th sck pulse while rdata still holds its reset value.
        @(negedge clk);
        bus.tdat = 8'hC3; bus.mlb = 1'b1; bus.cdiv = 2'd0; din_mode = 1; bus.start = 1'b1;
        rises = 0; ps = 1'b0;
        for (int c = 0; c < 200 && rises < 4; c++) begin
            @(negedge clk);
            if (c == 1) bus.start = 1'b0;
            if (bus.sck && !ps) rises++;
            ps = bus.sck;
        end
        chk("abort_reached_pulse4", 32'(rises), 32'd4);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_ss", 32'(bus.ss), 32'd1);
        chk("abort_sck", 32'(bus.sck), 32'd0);
        chk("abort_dout", 32'(bus.dout), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_rdata", 32'(bus.rdata), 32'd0);
        rst = 1'b0;
        had_xfer = 0;
        xfer(vecs[0]);

        for (int i = 0; i < 6; i++) xfer(vecs[i]);

        for (int i = 0; i < 12; i++) begin
            rv = '{frame[i], 1'b1, 2'd0, 1, 1'b0, 2, -1, 0, frame[i]};
            xfer(rv);
        end

        for (int i = 0; i < 24; i++) begin
            rv.tdat     = 8'($urandom);
            rv.mlb      = 1'($urandom);
            rv.cdiv     = 2'($urandom);
            rv.din_mode = ($urandom_range(0, 1) == 0) ? 1 : 2;
            rv.din_val  = 1'($urandom);
            rv.hold     = int'($urandom_range(1, 12));
            rv.repulse  = (rv.hold < 12) ? 14 : -1;
            rv.tail     = int'($urandom_range(0, 3));
            rv.exp_rd   = rv.tdat;
            xfer(rv);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

endmodule

// File: doc/spi_byte_master.md
Name: spi_byte_master

Overview:
- Single-byte SPI master. Shifts one 8-bit word out on dout and simultaneously captures 8 bits from din.
- Runs SPI mode 0 (CPOL=0, CPHA=0) with a selectable clock divider.
- Acts as the host-side model driving a board's MCU SPI slave port (sclk, n_cs, mosi, miso). Multi-byte packets, such as 12-byte command frames, are built by issuing back-to-back byte transfers.

Parameters:
- None. Word width is fixed at 8. Divider select width is fixed at 2.

Ports:
- clk    in   1  system clock; all logic on rising edge
- rst    in   1  synchronous reset, active-high
- mlb    in   1  bit order: 1 = MSB first, 0 = LSB first; latched at transfer start
- start  in   1  transfer request; its rising edge starts one byte transfer
- tdat   in   8  byte to transmit; latched at transfer start
- cdiv   in   2  sck divider: 00 -> clk/4, 01 -> clk/8, 10 -> clk/16, 11 -> clk/32; latched at transfer start
- din    in   1  serial data from slave (MISO)
- ss     out  1  slave select, active-low
- sck    out  1  serial clock, idles low
- dout   out  1  serial data to slave (MOSI)
- done   out  1  level; high = last transfer complete and rdata valid
- rdata  out  8  last received byte

Behaviour:
- Interface: one clock domain (clk). Reset rst is synchronous and active-high.
- Reset values: ss=1, sck=0, dout=0, done=0, rdata=0x00, state=IDLE.
- Reset asserted mid-transfer aborts the transfer on the next edge. All outputs return to reset values; rdata is not updated.
- start is registered and edge-detected. A transfer begins only on a 0->1 transition seen while in IDLE.
- start held high for multiple cycles produces exactly one transfer.
- Rising edges of start in any non-IDLE state are ignored.
- Half-period H = 2 << cdiv clocks, giving 2, 4, 8 or 16.
- States and transitions:
  - IDLE: ss=1, sck=0. On a start edge, go to LEAD on the next edge. At that edge: latch tdat/mlb/cdiv, set ss=0, drive dout with the first bit (tdat[7] if mlb=1, else tdat[0]), clear done.
  - LEAD: hold for H clocks with sck=0, then enter HIGH.
  - HIGH: sck=1 for H clocks. din is sampled into the receive shift register on the clk edge where sck goes 1.
  - LOW: sck=0 for H clocks. dout advances to the next bit on the edge where sck falls, for bits 1..7. After the 8th LOW phase, go to FIN.
  - FIN (single cycle): ss=1, done=1, rdata = captured byte, dout holds its last value. Return to IDLE.
- Transfer timing:
  - ss is low for exactly 17*H clocks (34 clocks at cdiv=00).
  - Exactly 8 sck pulses occur, each H clocks high.
- Receive bit order: with mlb=1, the first received bit lands in rdata[7]. With mlb=0, it lands in rdata[0].
- done stays high until the next transfer starts. That edge clears it in the same cycle ss falls.
- Back-to-back transfers: a new start edge in the cycle after FIN is accepted. There is no minimum gap beyond one IDLE cycle.
- cdiv or tdat changes during a transfer have no effect; they are latched values.

Decomposition:
- Shared package spi_byte_master_pkg holds:
  - state enum {IDLE, LEAD, HIGH, LOW, FIN};
  - constant WORD_W=8;
  - the function half_period(cdiv) returning 2<<cdiv.
- Sub-module: none required.
- Optionally, the phase counter can be factored into spi_half_period_timer (load H, count down, pulse tick at zero).

Test Plan:
- Loopback (din tied to dout), mlb=1, cdiv=00, tdat=0x5A, start pulsed 2 cycles -> ss low 34 clocks, 8 sck pulses at period 4 clocks, dout sequence 0,1,0,1,1,0,1,0, rdata=0x5A, done=1 after ss rises.
- mlb=0, cdiv=01, tdat=0x01, din held 1 -> dout sequence 1,0,0,0,0,0,0,0; sck period 8 clocks; ss low 68 clocks; rdata=0xFF.
- cdiv=11, tdat=0xA5, loopback -> sck high 16 clocks per pulse, ss low 272 clocks, rdata=0xA5.
- Re-pulse start mid-transfer, then hold start high 10 cycles -> exactly one transfer each; done low from start until FIN.
- rst asserted at the 4th sck pulse -> next cycle ss=1, sck=0, dout=0, done=0, rdata unchanged (0x00); a following start gives a clean full transfer.
- 12-byte back-to-back frame 5A 00 01 01 00 00 03 09 00 00 00 00, loopback, waiting on done between bytes -> each rdata equals the transmitted byte; ss rises after every byte.
